// File: rtl/mdu_if.sv
// Multiply/divide unit request/response bundle.
//   master drives: start, op, a, b, wr_hi, wr_lo, wdata
//   slave  drives: busy, hi, lo
interface mdu_if #(
  parameter int unsigned WIDTH = 32
) ();

  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             wr_hi;
  logic             wr_lo;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, wr_hi, wr_lo, wdata,
    input  busy, hi, lo
  );

  modport slave (
    input  start, op, a, b, wr_hi, wr_lo, wdata,
    output busy, hi, lo
  );

endinterface

// File: rtl/mdu.sv
// MIPS-style multiply/divide unit with HI/LO result registers.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high
//   bus    mdu_if.slave
//            start/op/a/b  launch mult(0), multu(1), div(2), divu(3)
//            wr_hi/wr_lo/wdata  mthi/mtlo writes (IDLE only)
//            busy  high for exactly MULT_LAT/DIV_LAT cycles after start
//            hi/lo result registers
// The arithmetic is combinational on the latched operands; the latency is
// purely the down-counter, and the result is committed on the last busy edge.
module mdu #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned MULT_LAT = 5,
  parameter int unsigned DIV_LAT  = 10
) (
  input logic  clk,
  input logic  reset,
  mdu_if.slave bus
);

  localparam int unsigned CNT_W = 6;
  localparam int unsigned PW    = 2 * WIDTH;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic             busy_q;

  // Multiply: sign- or zero-extend to 2*WIDTH, low 2*WIDTH bits of the product.
  logic [PW-1:0] a_ext;
  logic [PW-1:0] b_ext;
  logic [PW-1:0] prod;

  always_comb begin
    a_ext = '0;
    b_ext = '0;
    if (op_q[0]) begin
      a_ext = {{WIDTH{1'b0}}, a_q};
      b_ext = {{WIDTH{1'b0}}, b_q};
    end else begin
      a_ext = {{WIDTH{a_q[WIDTH-1]}}, a_q};
      b_ext = {{WIDTH{b_q[WIDTH-1]}}, b_q};
    end
    prod = a_ext * b_ext;
  end

  // Divide: sign-magnitude, quotient truncates toward zero, remainder follows
  // the dividend. The most-negative / -1 case falls out as q = most-negative,
  // r = 0 because the magnitude 2^(WIDTH-1) negates back onto itself.
  logic             div_signed;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] b_safe;
  logic [WIDTH-1:0] q_mag;
  logic [WIDTH-1:0] r_mag;
  logic [WIDTH-1:0] quot;
  logic [WIDTH-1:0] rem;
  logic             div_zero;

  always_comb begin
    div_signed = ~op_q[0];
    a_neg      = div_signed & a_q[WIDTH-1];
    b_neg      = div_signed & b_q[WIDTH-1];
    a_mag      = a_neg ? (~a_q + WIDTH'(1)) : a_q;
    b_mag      = b_neg ? (~b_q + WIDTH'(1)) : b_q;
    div_zero   = (b_q == '0);
    // Keep the divider defined on b=0; its result is discarded in that case.
    b_safe     = div_zero ? WIDTH'(1) : b_mag;
    q_mag      = a_mag / b_safe;
    r_mag      = a_mag % b_safe;
    quot       = (a_neg ^ b_neg) ? (~q_mag + WIDTH'(1)) : q_mag;
    rem        = a_neg ? (~r_mag + WIDTH'(1)) : r_mag;
  end

  // Control FSM, operand latch, latency counter and HI/LO registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            // start wins over a same-cycle mthi/mtlo
            op_q    <= bus.op;
            a_q     <= bus.a;
            b_q     <= bus.b;
            cnt_q   <= bus.op[1] ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
            busy_q  <= 1'b1;
            state_q <= RUN;
          end else begin
            if (bus.wr_hi) hi_q <= bus.wdata;
            if (bus.wr_lo) lo_q <= bus.wdata;
          end
        end
        RUN: begin
          // start and writes are ignored while running
          if (cnt_q == CNT_W'(1)) begin
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
            if (!op_q[1]) begin
              hi_q <= prod[PW-1:WIDTH];
              lo_q <= prod[WIDTH-1:0];
            end else if (!div_zero) begin
              hi_q <= rem;
              lo_q <= quot;
            end
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: table of operations with constant expected
// HI/LO, scoreboard queue pushed at start and popped when busy falls, plus
// hand-written sequences for busy-time requests, start/write collisions and
// mid-operation reset.
module tb_mdu;

  localparam int unsigned WIDTH    = 32;
  localparam int unsigned MULT_LAT = 5;
  localparam int unsigned DIV_LAT  = 10;

  logic clk;
  logic reset;

  mdu_if #(.WIDTH(WIDTH)) bus ();

  mdu #(
    .WIDTH    (WIDTH),
    .MULT_LAT (MULT_LAT),
    .DIV_LAT  (DIV_LAT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
  } res_t;

  res_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Launch one op, scramble operand inputs after the start edge, count busy
  // cycles, then pop the scoreboard and compare HI/LO.
  // inj: busy cycle in which a div 9/3 start and wr_lo=0xAA are pulsed (0 = none).
  // wr_with: assert wr_hi with wd in the start cycle.
  task automatic run_op(input string name, input logic [1:0] op_i,
                        input logic [31:0] a_i, input logic [31:0] b_i,
                        input int lat, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo, input int inj,
                        input logic wr_with, input logic [31:0] wd);
    res_t r;
    int   n;
    r.hi = exp_hi;
    r.lo = exp_lo;
    sb_q.push_back(r);
    bus.start = 1'b1;
    bus.op    = op_i;
    bus.a     = a_i;
    bus.b     = b_i;
    bus.wr_hi = wr_with;
    bus.wdata = wd;
    tick();
    bus.start = 1'b0;
    bus.wr_hi = 1'b0;
    bus.a     = $urandom;
    bus.b     = $urandom;
    n = 0;
    while (bus.busy === 1'b1 && n < 200) begin
      n++;
      if (n == inj) begin
        bus.start = 1'b1;
        bus.op    = 2'd2;
        bus.a     = 32'd9;
        bus.b     = 32'd3;
        bus.wr_lo = 1'b1;
        bus.wdata = 32'h0000_00AA;
      end else begin
        bus.start = 1'b0;
        bus.wr_lo = 1'b0;
      end
      tick();
    end
    bus.start = 1'b0;
    bus.wr_lo = 1'b0;
    chk({name, "_busy_len"}, 32'(n), 32'(lat));
    if (sb_q.size() == 0) begin
      chk({name, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      r = sb_q.pop_front();
      chk({name, "_hi"}, bus.hi, r.hi);
      chk({name, "_lo"}, bus.lo, r.lo);
    end
  endtask

  vec_t vecs[11];

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{2'd0, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA};
    vecs[1]  = '{2'd1, 32'hFFFF_FFFE, 32'h0000_0003, 32'h0000_0002, 32'hFFFF_FFFA};
    vecs[2]  = '{2'd2, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3]  = '{2'd3, 32'h0000_0007, 32'h0000_0002, 32'h0000_0001, 32'h0000_0003};
    vecs[4]  = '{2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    vecs[5]  = '{2'd2, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
    vecs[6]  = '{2'd2, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0003};
    vecs[7]  = '{2'd3, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 32'h0FFF_FFFF};
    vecs[8]  = '{2'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    vecs[9]  = '{2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    // divu by zero keeps the previous row's HI/LO
    vecs[10] = '{2'd3, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFE, 32'h0000_0001};

    // Reset with start and writes asserted: reset wins.
    reset     = 1'b1;
    bus.start = 1'b1;
    bus.op    = 2'd0;
    bus.a     = 32'd3;
    bus.b     = 32'd3;
    bus.wr_hi = 1'b1;
    bus.wr_lo = 1'b1;
    bus.wdata = 32'h0000_FFFF;
    tick();
    tick();
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_hi", bus.hi, 32'd0);
    chk("rst_lo", bus.lo, 32'd0);
    reset     = 1'b0;
    bus.start = 1'b0;
    bus.wr_hi = 1'b0;
    bus.wr_lo = 1'b0;
    tick();
    chk("idle_busy", 32'(bus.busy), 32'd0);

    // mthi + mtlo together
    bus.wr_hi = 1'b1;
    bus.wr_lo = 1'b1;
    bus.wdata = 32'h0000_CAFE;
    tick();
    bus.wr_hi = 1'b0;
    bus.wr_lo = 1'b0;
    chk("wr_both_hi", bus.hi, 32'h0000_CAFE);
    chk("wr_both_lo", bus.lo, 32'h0000_CAFE);

    // mthi then div by zero: registers unchanged after full latency
    bus.wr_hi = 1'b1;
    bus.wdata = 32'h0000_1234;
    tick();
    bus.wr_hi = 1'b0;
    chk("mthi", bus.hi, 32'h0000_1234);
    run_op("div0", 2'd2, 32'd5, 32'd0, DIV_LAT, 32'h0000_1234, 32'h0000_CAFE, 0, 1'b0, 32'd0);

    for (int i = 0; i < 11; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
             vecs[i].op[1] ? DIV_LAT : MULT_LAT, vecs[i].exp_hi, vecs[i].exp_lo,
             0, 1'b0, 32'd0);
    end

    // start and wr_lo during busy cycle 2 are ignored
    run_op("busy_req", 2'd1, 32'd2, 32'd3, MULT_LAT, 32'd0, 32'd6, 2, 1'b0, 32'd0);
    tick();
    chk("busy_req_after_busy", 32'(bus.busy), 32'd0);
    chk("busy_req_after_lo", bus.lo, 32'd6);

    // start together with mthi: write dropped
    run_op("start_wr", 2'd0, 32'd4, 32'd5, MULT_LAT, 32'd0, 32'd20, 0, 1'b1, 32'h0000_0055);
    run_op("start_wr_div0", 2'd3, 32'd1, 32'd0, DIV_LAT, 32'd0, 32'd20, 0, 1'b1, 32'h0000_0099);

    // reset in busy cycle 3 of a divide
    bus.wr_lo = 1'b1;
    bus.wdata = 32'h0000_0077;
    tick();
    bus.wr_lo = 1'b0;
    chk("mtlo", bus.lo, 32'h0000_0077);
    bus.start = 1'b1;
    bus.op    = 2'd2;
    bus.a     = 32'd100;
    bus.b     = 32'd7;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    chk("mid_busy", 32'(bus.busy), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);
    chk("mid_rst_hi", bus.hi, 32'd0);
    chk("mid_rst_lo", bus.lo, 32'd0);
    repeat (12) tick();
    chk("mid_rst_late_busy", 32'(bus.busy), 32'd0);
    chk("mid_rst_late_hi", bus.hi, 32'd0);
    chk("mid_rst_late_lo", bus.lo, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mdu.md
MDU -- requirements
Module: mdu

Interface
REQ-001 Parameter WIDTH, default 32, operand and HI/LO width in bits.
REQ-002 Parameter MULT_LAT, default 5, busy cycles for mult/multu; legal range 1..63.
REQ-003 Parameter DIV_LAT, default 10, busy cycles for div/divu; legal range 1..63.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset  input  1  synchronous, active-high; clock clk.
REQ-006 start  input  1  launch operation in op with operands a, b.
REQ-007 op  input  2  0=mult (signed), 1=multu, 2=div (signed), 3=divu.
REQ-008 a  input  WIDTH  first operand (multiplicand / dividend).
REQ-009 b  input  WIDTH  second operand (multiplier / divisor).
REQ-010 wr_hi  input  1  mthi: write wdata to HI.
REQ-011 wr_lo  input  1  mtlo: write wdata to LO.
REQ-012 wdata  input  WIDTH  data for wr_hi / wr_lo.
REQ-013 busy  output  1  operation in progress.
REQ-014 hi  output  WIDTH  HI register, read by mfhi.
REQ-015 lo  output  WIDTH  LO register, read by mflo.

Function
REQ-016 FSM states: IDLE and RUN; a down-counter holds the remaining busy cycles.
REQ-017 IDLE + start at edge T: latch op, a, b; load counter to MULT_LAT or DIV_LAT; go to RUN.
REQ-018 busy is 1 for exactly LAT cycles after the start edge and is driven from a register, not combinationally from start.
REQ-019 At the edge that ends the last busy cycle: write HI/LO, go to IDLE; the new HI/LO is visible in the same cycle busy reads 0.
REQ-020 mult/multu: the 2*WIDTH product is computed from the latched operands; HI = upper WIDTH bits, LO = lower WIDTH bits.
REQ-021 mult sign-extends both operands; multu zero-extends both operands.
REQ-022 div/divu: LO = quotient, HI = remainder.
REQ-023 div quotient truncates toward zero; the remainder takes the sign of the dividend.
REQ-024 div overflow (a = most-negative, b = -1): LO = most-negative, HI = 0.
REQ-025 Divide by zero (b=0, div or divu): full LAT busy cycles, then HI and LO stay unchanged.
REQ-026 start while busy is ignored; the running operation and its latched operands are unaffected.
REQ-027 wr_hi/wr_lo while busy are ignored.
REQ-028 wr_hi/wr_lo in IDLE update the register at the edge; the new value is visible the next cycle.
REQ-029 wr_hi and wr_lo together write wdata to both registers.
REQ-030 start and wr_hi/wr_lo in the same IDLE cycle: start wins and the write is dropped.
REQ-031 Results must not depend on operand inputs after the start edge.
REQ-032 Latency is a pure counter; the arithmetic may be single-cycle or iterative internally, provided REQ-018/019 timing holds exactly.

Reset
REQ-033 reset at any edge, including mid-operation: state IDLE, counter 0, busy 0, hi 0, lo 0; any in-flight result is discarded.
REQ-034 reset has priority over start, wr_hi and wr_lo in the same cycle.

Verification
REQ-035 Signed multiply: mult, a=0xFFFFFFFE, b=3 -> busy 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA. Unsigned multiply: multu with the same operands -> hi=0x00000002, lo=0xFFFFFFFA.
REQ-036 Signed divide: div, a=0xFFFFFFF9 (-7), b=2 -> busy 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF. Unsigned divide: divu, a=7, b=2 -> lo=3, hi=1.
REQ-037 Divide by zero and overflow: mthi 0x1234 then div by 0 -> busy 10 cycles, hi stays 0x1234; div 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-038 Requests while busy: start multu 2*3; in busy cycle 2 pulse start (div 9/3) and wr_lo=0xAA -> both ignored; final hi=0, lo=6.
REQ-039 Simultaneous start and write: start mult 4*5 together with wr_hi=0x55 -> hi=0, lo=20 after 5 busy cycles.
REQ-040 Reset mid-operation: mtlo 0x77, start div 100/7, assert reset in busy cycle 3 -> next cycle busy=0, hi=0, lo=0; no later update.
